// File: rtl/uart_tx_buf_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM encoding and line levels.
package uart_tx_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // One start bit, eight data bits, one stop bit.
  localparam int FRAME_BITS = 10;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/uart_tx_buf_byte_fifo.sv
// Byte FIFO feeding the serializer: drop-on-full writes with a sticky overflow
// flag, a pop strobe, and the head entry presented for loading on the pop edge.
module uart_tx_buf_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          overflow
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          overflow_reg;
  logic          wr_ok;
  logic          pop_ok;

  // Fullness comes from the registered count, so a same-cycle pop never frees a slot.
  assign full   = (count_reg == (AW+1)'(DEPTH));
  assign empty  = (count_reg == '0);
  assign wr_ok  = wr_en && !full;
  assign pop_ok = pop && !empty;

  // The head is taken straight from the storage registers so the shifter can
  // capture it on the same edge that retires the entry.
  assign head     = mem[rd_ptr_reg];
  assign count    = count_reg;
  assign overflow = overflow_reg;

  // Storage array: contents are not reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (wr_en && full) begin
        overflow_reg <= 1'b1;
      end
      case ({wr_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: bursts land in a byte FIFO and are sent
// back-to-back at CLK_PER_BIT clocks per bit with a registered txd.
module uart_tx_buf
  import uart_tx_buf_pkg::*;
#(
  parameter int CLK_PER_BIT = 104,
  parameter int DEPTH       = 16,
  parameter int AW          = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  input  logic [7:0]    in_data,
  output logic          txd,
  output logic          busy,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic [AW:0]   count
);

  localparam int BW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_PER_BIT - 1);
  // Index of the last data bit: frame minus start and stop, counted from zero.
  localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 3);

  uart_state_t   state_reg, state_next;
  logic [BW-1:0] baud_reg, baud_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          txd_reg, txd_next;
  logic          pop;
  logic [7:0]    head;
  logic          baud_end;

  uart_tx_buf_byte_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (in_vld),
    .wr_data  (in_data),
    .pop      (pop),
    .head     (head),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow)
  );

  assign baud_end = (baud_reg == BAUD_LAST);
  assign txd      = txd_reg;
  assign busy     = (state_reg != ST_IDLE);

  // Serializer state registers; reset aborts any frame and forces the line idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      txd_reg   <= IDLE_LVL;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      txd_reg   <= txd_next;
    end
  end

  // Next-state logic: frame sequencing, bit timing and FIFO pops at frame start.
  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    txd_next   = txd_reg;
    pop        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        baud_next = '0;
        bit_next  = '0;
        txd_next  = IDLE_LVL;
        if (!empty) begin
          pop        = 1'b1;
          shift_next = head;
          txd_next   = START_LVL;
          state_next = ST_START;
        end
      end
      ST_START: begin
        baud_next = baud_reg + 1'b1;
        if (baud_end) begin
          baud_next  = '0;
          bit_next   = '0;
          txd_next   = shift_reg[0];
          shift_next = shift_reg >> 1;
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        baud_next = baud_reg + 1'b1;
        if (baud_end) begin
          baud_next = '0;
          if (bit_reg == LAST_BIT) begin
            txd_next   = STOP_LVL;
            state_next = ST_STOP;
          end else begin
            txd_next   = shift_reg[0];
            shift_next = shift_reg >> 1;
            bit_next   = bit_reg + 1'b1;
          end
        end
      end
      ST_STOP: begin
        baud_next = baud_reg + 1'b1;
        if (baud_end) begin
          baud_next = '0;
          if (!empty) begin
            // Chain straight into the next start bit with no idle gap.
            pop        = 1'b1;
            shift_next = head;
            txd_next   = START_LVL;
            state_next = ST_START;
          end else begin
            txd_next   = IDLE_LVL;
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        txd_next   = IDLE_LVL;
      end
    endcase
  end

endmodule
